// File: rtl/uart_bus_slave.sv
// uart_bus_slave
//   Slave end of the uncached IO-bus transaction for the UART. Decodes the
//   master's read/write strobes, checks/generates 33-bit even parity, maps a
//   16-byte register window and buffers received bytes in a small FIFO.
//
//   Register window (addr[3:2]):
//     0 TXDATA (W)  byte goes to the transmitter once tx_busy is low
//     1 RXDATA (R)  pops one FIFO entry, reads 0 when the FIFO is empty
//     2 STATUS (R)  {28'b0, overrun, tx_busy, rx_full, rx_not_empty}
//     3 CTRL  (RW)  bit0 rx_en, writing bit3 = 1 clears overrun
//
//   Ports:
//     clk, resetn                  clock, async active-low reset
//     rw1, master_uart_addr        read request (rw1 = 0) and address
//     master_uart_write_ready      write strobe, data follows one cycle later
//     master_uart_write_data       {parity, data}
//     uart_master_write_ready      read-data valid pulse
//     uart_master_data             {parity, read data}, held between reads
//     mem_write_finish, bus_error  write-done / error pulses
//     tx_data, tx_start, tx_busy   transmitter handshake
//     rx_data, rx_valid            receiver byte strobe
module uart_bus_slave #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          RX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rw1,
  input  logic [31:0] master_uart_addr,
  input  logic        master_uart_write_ready,
  input  logic [32:0] master_uart_write_data,
  output logic        uart_master_write_ready,
  output logic [32:0] uart_master_data,
  output logic        mem_write_finish,
  output logic        bus_error,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(RX_DEPTH);

  localparam logic [1:0] R_TX   = 2'd0;
  localparam logic [1:0] R_RX   = 2'd1;
  localparam logic [1:0] R_STAT = 2'd2;
  localparam logic [1:0] R_CTRL = 2'd3;

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_TX, RD_RESP, ERR} state_t;

  state_t        state, state_nxt;
  logic [31:0]   addr_q;
  logic [7:0]    tx_byte_q;
  logic          rx_en, overrun, fin_pend;

  logic [7:0]    fifo_mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic          latch_addr, do_rd, do_ctrl, do_tx, do_err;
  logic          in_ok, q_ok, wpar_ok;
  logic [1:0]    in_reg, q_reg;
  logic          rx_full, rx_nempty, push, pop, accept;
  logic [31:0]   rdata;

  // Window hit: upper address bits match and the access is word aligned.
  assign in_ok   = (master_uart_addr[31:4] == BASE_ADDR[31:4]) && (master_uart_addr[1:0] == 2'b00);
  assign q_ok    = (addr_q[31:4] == BASE_ADDR[31:4]) && (addr_q[1:0] == 2'b00);
  assign in_reg  = master_uart_addr[3:2];
  assign q_reg   = addr_q[3:2];
  assign wpar_ok = ~(^master_uart_write_data);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    latch_addr = 1'b0;
    do_rd      = 1'b0;
    do_ctrl    = 1'b0;
    do_tx      = 1'b0;
    do_err     = 1'b0;
    case (state)
      IDLE: begin
        if (master_uart_write_ready) begin
          latch_addr = 1'b1;
          state_nxt  = WR_DATA;
        end else if (!rw1) begin
          latch_addr = 1'b1;
          state_nxt  = (in_ok && in_reg != R_TX) ? RD_RESP : ERR;
        end
      end
      WR_DATA: begin
        if (!wpar_ok || !q_ok || q_reg == R_RX || q_reg == R_STAT)
          state_nxt = ERR;
        else if (q_reg == R_TX)
          state_nxt = WR_TX;
        else begin
          do_ctrl   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WR_TX: begin
        if (!tx_busy) begin
          do_tx     = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD_RESP: begin
        do_rd     = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        do_err    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q    <= '0;
      tx_byte_q <= '0;
    end else begin
      if (latch_addr)        addr_q    <= master_uart_addr;
      if (state == WR_DATA)  tx_byte_q <= master_uart_write_data[7:0];
    end
  end

  // RX FIFO
  assign rx_full   = (count == DEPTH_C);
  assign rx_nempty = (count != '0);
  assign push      = rx_valid && rx_en;
  assign pop       = do_rd && (q_reg == R_RX) && rx_nempty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign accept    = push && (!rx_full || pop);

  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      case ({accept, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Control register and sticky overrun; a new overflow beats a clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_en   <= 1'b1;
      overrun <= 1'b0;
    end else begin
      if (do_ctrl) begin
        rx_en <= master_uart_write_data[0];
        if (master_uart_write_data[3]) overrun <= 1'b0;
      end
      if (push && rx_full && !pop) overrun <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    case (q_reg)
      R_RX:    rdata = rx_nempty ? {24'b0, fifo_mem[rd_ptr]} : 32'b0;
      R_STAT:  rdata = {28'b0, overrun, tx_busy, rx_full, rx_nempty};
      R_CTRL:  rdata = {31'b0, rx_en};
      default: rdata = '0;
    endcase
  end

  // Response outputs. A CTRL write finishes one cycle after its data is
  // taken so it lines up with a TXDATA write that sees tx_busy low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      uart_master_write_ready <= 1'b0;
      uart_master_data        <= '0;
      mem_write_finish        <= 1'b0;
      bus_error               <= 1'b0;
      tx_data                 <= '0;
      tx_start                <= 1'b0;
      fin_pend                <= 1'b0;
    end else begin
      uart_master_write_ready <= do_rd;
      if (do_rd) uart_master_data <= {^rdata, rdata};
      fin_pend                <= do_ctrl;
      mem_write_finish        <= fin_pend | do_tx;
      bus_error               <= do_err;
      tx_start                <= do_tx;
      if (do_tx) tx_data <= tx_byte_q;
    end
  end

endmodule

// File: tb/tb_uart_bus_slave.sv
// Bench for uart_bus_slave: a transaction-level model schedules expected
// response pulses by absolute cycle number; one compare process checks all
// outputs every cycle. Literal checks pin key values from the test plan.
module tb_uart_bus_slave;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          DEPTH = 4;

  logic        clk, resetn, rw1;
  logic [31:0] master_uart_addr;
  logic        master_uart_write_ready;
  logic [32:0] master_uart_write_data;
  logic        uart_master_write_ready;
  logic [32:0] uart_master_data;
  logic        mem_write_finish, bus_error;
  logic [7:0]  tx_data;
  logic        tx_start, tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid;

  uart_bus_slave #(.BASE_ADDR(BASE), .RX_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .rw1(rw1),
    .master_uart_addr(master_uart_addr),
    .master_uart_write_ready(master_uart_write_ready),
    .master_uart_write_data(master_uart_write_data),
    .uart_master_write_ready(uart_master_write_ready),
    .uart_master_data(uart_master_data),
    .mem_write_finish(mem_write_finish), .bus_error(bus_error),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Expected events keyed by cycle number
  logic [32:0] exp_rd  [int];
  bit          exp_fin [int];
  bit          exp_err [int];
  logic [7:0]  exp_tx  [int];
  logic [32:0] last_data = '0;
  logic [7:0]  last_tx   = '0;

  // Register model
  logic [7:0] m_q[$];
  bit         m_ovr  = 1'b0;
  bit         m_rxen = 1'b1;

  task automatic chk(string nm, logic [32:0] got, logic [32:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
  endtask

  // Compare process
  initial begin
    bit e_rdy, e_fin, e_err, e_tx;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!resetn) begin
        chk("rst_rdy",   uart_master_write_ready, 0);
        chk("rst_data",  uart_master_data, 0);
        chk("rst_fin",   mem_write_finish, 0);
        chk("rst_err",   bus_error, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_txd",   tx_data, 0);
      end else begin
        e_rdy = exp_rd.exists(cyc);
        e_fin = exp_fin.exists(cyc);
        e_err = exp_err.exists(cyc);
        e_tx  = exp_tx.exists(cyc);
        if (e_rdy) last_data = exp_rd[cyc];
        if (e_tx)  last_tx   = exp_tx[cyc];
        chk("rd_ready", uart_master_write_ready, e_rdy);
        chk("rd_data",  uart_master_data, last_data);
        chk("finish",   mem_write_finish, e_fin);
        chk("bus_err",  bus_error, e_err);
        chk("tx_start", tx_start, e_tx);
        chk("tx_data",  tx_data, last_tx);
      end
    end
  end

  function automatic bit win_ok(logic [31:0] a);
    return (a[31:4] == BASE[31:4]) && (a[1:0] == 2'b00);
  endfunction

  task automatic push_rx(logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    if (m_rxen) begin
      if (m_q.size() < DEPTH) m_q.push_back(b);
      else m_ovr = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_read(logic [31:0] a);
    int c;
    logic [31:0] d;
    @(negedge clk);
    c = cyc;
    rw1 = 1'b0;
    master_uart_addr = a;
    if (!win_ok(a) || a[3:2] == 2'd0) exp_err[c+2] = 1'b1;
    else begin
      d = 32'b0;
      case (a[3:2])
        2'd1: if (m_q.size() != 0) d = {24'b0, m_q.pop_front()};
        2'd2: d = {28'b0, m_ovr, tx_busy, m_q.size() == DEPTH, m_q.size() != 0};
        default: d = {31'b0, m_rxen};
      endcase
      exp_rd[c+2] = {^d, d};
    end
    @(negedge clk);
    rw1 = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // busy = number of WR_TX cycles that see tx_busy high
  task automatic do_write(logic [31:0] a, logic [32:0] w, int busy);
    int c;
    @(negedge clk);
    c = cyc;
    master_uart_write_ready = 1'b1;
    master_uart_addr = a;
    @(negedge clk);
    master_uart_write_ready = 1'b0;
    master_uart_write_data  = w;
    if (busy > 0) tx_busy = 1'b1;
    if ((^w) != 1'b0 || !win_ok(a) || a[3:2] == 2'd1 || a[3:2] == 2'd2)
      exp_err[c+3] = 1'b1;
    else if (a[3:2] == 2'd0) begin
      exp_fin[c+3+busy] = 1'b1;
      exp_tx[c+3+busy]  = w[7:0];
    end else begin
      exp_fin[c+3] = 1'b1;
      m_rxen = w[0];
      if (w[3]) m_ovr = 1'b0;
    end
    repeat (busy + 1) @(negedge clk);
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; rw1 = 1'b1; master_uart_addr = '0;
    master_uart_write_ready = 1'b0; master_uart_write_data = '0;
    tx_busy = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // STATUS after reset
    do_read(BASE + 32'h8);
    chk("lit_status_reset", uart_master_data, 33'h0_0000_0000);

    // RX path
    push_rx(8'h41);
    push_rx(8'h42);
    do_read(BASE + 32'h4);
    chk("lit_rx0", uart_master_data, 33'h0_0000_0041);
    do_read(BASE + 32'h4);
    chk("lit_rx1", uart_master_data, 33'h0_0000_0042);
    do_read(BASE + 32'h4);
    chk("lit_rx_empty", uart_master_data, 33'h0_0000_0000);

    // TX with busy for 3 cycles, then TX with no busy
    do_write(BASE, 33'h0_0000_0055, 3);
    chk("lit_tx55", tx_data, 8'h55);
    do_write(BASE, 33'h0_0000_0001, 0);   // bad parity
    chk("lit_tx_hold", tx_data, 8'h55);
    do_write(BASE, 33'h1_0000_00A7, 0);
    chk("lit_txA7", tx_data, 8'hA7);

    // Overrun and clear
    for (int i = 1; i <= 5; i++) push_rx(8'(i));
    do_read(BASE + 32'h8);
    chk("lit_status_ovr", uart_master_data, 33'h1_0000_000B);
    do_write(BASE + 32'hC, 33'h0_0000_0009, 0);
    do_read(BASE + 32'h8);
    chk("lit_status_clr", uart_master_data, 33'h0_0000_0003);
    for (int i = 0; i < 4; i++) do_read(BASE + 32'h4);
    chk("lit_rx_last", uart_master_data, 33'h1_0000_0004);

    // rx_en off drops bytes without overrun
    do_write(BASE + 32'hC, 33'h0_0000_0000, 0);
    push_rx(8'h77);
    do_read(BASE + 32'h8);
    chk("lit_status_rxoff", uart_master_data, 33'h0_0000_0000);
    do_read(BASE + 32'hC);
    do_write(BASE + 32'hC, 33'h1_0000_0001, 0);
    do_read(BASE + 32'hC);
    chk("lit_ctrl", uart_master_data, 33'h1_0000_0001);

    // Error cases
    do_read(BASE + 32'h1);
    do_read(BASE + 32'h10);
    do_read(BASE);                              // TXDATA is write-only
    do_write(BASE + 32'h8, 33'h0_0000_0000, 0); // STATUS is read-only
    do_write(BASE + 32'hC, 33'h0_0000_0008, 0); // bad parity on CTRL
    do_write(BASE + 32'h14, 33'h0_0000_0000, 0);
    do_read(BASE + 32'hC);
    chk("lit_ctrl_kept", uart_master_data, 33'h1_0000_0001);

    // Reset in the middle of WR_TX: no finish, everything back to reset
    @(negedge clk);
    master_uart_write_ready = 1'b1;
    master_uart_addr = BASE;
    @(negedge clk);
    master_uart_write_ready = 1'b0;
    master_uart_write_data  = 33'h0_0000_0033;
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    exp_rd.delete(); exp_fin.delete(); exp_err.delete(); exp_tx.delete();
    last_data = '0; last_tx = '0;
    m_q.delete(); m_ovr = 1'b0; m_rxen = 1'b1;
    tx_busy = 1'b0;
    @(negedge clk);
    chk("lit_rst_fin", mem_write_finish, 0);
    chk("lit_rst_txd", tx_data, 0);
    chk("lit_rst_data", uart_master_data, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    do_read(BASE + 32'hC);
    chk("lit_ctrl_after_rst", uart_master_data, 33'h1_0000_0001);
    do_read(BASE + 32'h8);
    chk("lit_status_after_rst", uart_master_data, 33'h0_0000_0000);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
